cdc_2phase_dst_mux: RTL and testbench
=====================================

CDC_2PHASE_DST_MUX -- requirements
Module: cdc_2phase_dst_mux

Interface
REQ-001 Parameter T, default logic: payload type carried by every channel.
REQ-002 Parameter NumChan, default 2: number of independent 2-phase input channels; legal range 1..32.
REQ-003 Parameter SyncStages, default 2: flip-flops in each req synchroniser chain; legal minimum 2.
REQ-004 Localparam IdxWidth = max(1, clog2(NumChan)).
REQ-005 clk_i  input  1  sole clock; all state is sampled on its rising edge.
REQ-006 rst_ni  input  1  reset; asynchronous, active-low.
REQ-007 async_req_i  input  [NumChan]  per-channel 2-phase request; a level toggle means new data is offered.
REQ-008 async_ack_o  output  [NumChan]  per-channel 2-phase acknowledge; a level toggle means the data was consumed.
REQ-009 async_data_i  input  [NumChan] x T  per-channel payload; held stable by the sender from its req toggle until it sees the matching ack toggle.
REQ-010 data_o  output  T  payload at the head of the output stream.
REQ-011 idx_o  output  IdxWidth  index of the channel that supplied data_o.
REQ-012 valid_o  output  1  output stream valid.
REQ-013 ready_i  input  1  output stream ready.

Function
REQ-014 Each channel c shall synchronise async_req_i[c] through SyncStages flops; req_sync[c] is the output of the last stage.
REQ-015 Channel c shall be pending when req_sync[c] != ack_q[c], where ack_q[c] is the registered value driving async_ack_o[c].
REQ-016 The output register is free when valid_o=0, or when valid_o=1 and ready_i=1 in the same cycle.
REQ-017 When the output register is free and at least one channel is pending, the round-robin winner g shall be loaded at the next edge: data_o<=async_data_i[g], idx_o<=g, valid_o<=1, ack_q[g]<=~ack_q[g].
REQ-018 No other channel's ack_q shall change at that edge; at most one ack toggles per cycle.
REQ-019 Round-robin: priority starts at (last_grant+1) mod NumChan; last_grant updates only on a load.
REQ-020 When the output register is free and no channel is pending, valid_o shall be 0 at the next edge and data_o/idx_o shall hold their values.
REQ-021 While valid_o=1 and ready_i=0, data_o, idx_o and valid_o shall remain stable.
REQ-022 Latency: a req toggle that is settled before edge k shall produce valid_o=1 after edge k+SyncStages, provided the output is free and no other channel wins arbitration.
REQ-023 Throughput: one item per cycle across channels when several channels are pending and ready_i=1 is held.
REQ-024 A channel shall not be re-granted until its req toggles again; its ack toggle clears pending in the same cycle.
REQ-025 With NumChan=1, idx_o shall be constantly 0 and the arbiter shall degenerate to a pass-through.

Reset
REQ-026 While rst_ni=0: all synchroniser flops=0, ack_q=0, valid_o=0, data_o='0, idx_o=0, last_grant=NumChan-1.
REQ-027 Reset asserted mid-transfer shall discard the output item and clear all acks; the senders shall be reset concurrently (system-level rule).
REQ-028 After reset deassertion, channel 0 shall have the highest priority.

Structure
REQ-029 No shared-package typedefs are required; IdxWidth and the index type shall be local to the module.
REQ-030 The per-channel synchroniser shall instantiate the existing sync cell (parameter STAGES=SyncStages); the round-robin arbiter shall be implemented inline.
REQ-031 Synchroniser flops and async_ack_o drivers shall carry dont_touch, and synchroniser flops shall also carry async_reg.

Verification
REQ-032 NumChan=1, SyncStages=2: toggle req with data 0xA5 -> valid_o=1 two edges later with data_o=0xA5 and ack toggled; ready_i=1 -> valid_o=0 next cycle.
REQ-033 NumChan=4: all channels toggle at once with data 0x10..0x13, ready_i=1 -> idx_o sequence 0,1,2,3 on consecutive cycles, each ack toggling exactly once.
REQ-034 Backpressure: ready_i=0 for 5 cycles with 2 channels pending -> data_o/idx_o stable for all 5 cycles; only the first winner's ack has toggled.
REQ-035 Fairness: channels 0 and 2 re-toggle immediately after each ack, ready_i=1 -> grants alternate 0,2,0,2; neither channel is granted twice in a row.
REQ-036 Reset at the cycle valid_o=1 -> valid_o=0, all async_ack_o=0 while rst_ni=0; after deassertion, the first grant goes to channel 0.
REQ-037 Random scoreboard, SyncStages=3, 10k items per channel -> no loss, no duplication, per-channel order preserved.

Source files
------------

// File: rtl/cdc_2phase_dst_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module : cdc_2phase_dst_mux_pkg -- helpers for the 2-phase destination mux
// Rev    : 1.0
// ============================================================================
package cdc_2phase_dst_mux_pkg;

  // An index needs at least one bit, even for a single channel.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cdc_2phase_dst_mux_sync.sv
`default_nettype none
// ============================================================================
// Module : cdc_2phase_dst_mux_sync -- multi-flop level synchroniser cell
// Rev    : 1.0
// ============================================================================
module cdc_2phase_dst_mux_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  (* dont_touch = "true", async_reg = "true" *) logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/cdc_2phase_dst_mux.sv
`default_nettype none
// ============================================================================
// Module : cdc_2phase_dst_mux -- N 2-phase req/ack channels merged round-robin
//          into one valid/ready stream in the destination clock domain
// Rev    : 1.0
// ============================================================================
module cdc_2phase_dst_mux
  import cdc_2phase_dst_mux_pkg::*;
#(
  parameter type T          = logic,
  parameter int  NumChan    = 2,
  parameter int  SyncStages = 2,
  localparam int IdxWidth   = idx_width(NumChan)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumChan-1:0]  async_req_i,
  output logic [NumChan-1:0]  async_ack_o,
  input  T                    async_data_i [NumChan],
  output T                    data_o,
  output logic [IdxWidth-1:0] idx_o,
  output logic                valid_o,
  input  logic                ready_i
);

  typedef logic [IdxWidth-1:0] idx_t;

  logic [NumChan-1:0] req_sync;
  (* dont_touch = "true" *) logic [NumChan-1:0] ack_q;
  logic [NumChan-1:0] ack_d;
  logic [NumChan-1:0] pending;
  logic               valid_q, valid_d;
  T                   data_q, data_d;
  idx_t               idx_q, idx_d;
  idx_t               last_q, last_d;
  logic               out_free;
  logic               grant_found;
  idx_t               grant_idx;
  T                   grant_data;
  int                 cand;

  for (genvar c = 0; c < NumChan; c++) begin : g_sync
    cdc_2phase_dst_mux_sync #(
      .STAGES (SyncStages)
    ) u_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (async_req_i[c]),
      .q_o    (req_sync[c])
    );
  end

  assign pending  = req_sync ^ ack_q;
  assign out_free = ~valid_q | ready_i;

  // Search starts one past the last winner, so a just-served channel goes last.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 0; i < NumChan; i++) begin
      cand = (int'(last_q) + 1 + i) % NumChan;
      if (!grant_found && pending[cand]) begin
        grant_found = 1'b1;
        grant_idx   = idx_t'(cand);
      end
    end
  end

  assign grant_data = async_data_i[grant_idx];

  always_comb begin
    ack_d   = ack_q;
    valid_d = valid_q;
    data_d  = data_q;
    idx_d   = idx_q;
    last_d  = last_q;
    if (out_free) begin
      if (grant_found) begin
        valid_d            = 1'b1;
        data_d             = grant_data;
        idx_d              = grant_idx;
        last_d             = grant_idx;
        ack_d[grant_idx]   = ~ack_q[grant_idx];
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      last_q  <= idx_t'(NumChan - 1);
    end else begin
      ack_q   <= ack_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
    end
  end

  assign async_ack_o = ack_q;
  assign valid_o     = valid_q;
  assign data_o      = data_q;
  assign idx_o       = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_cdc_2phase_dst_mux.sv
`default_nettype none
// ============================================================================
// Module : tb_cdc_2phase_dst_mux -- scoreboard bench for the 2-phase dst mux
// Rev    : 1.0
// ============================================================================
module tb_cdc_2phase_dst_mux;

  localparam int NCH = 4;

  typedef struct packed {
    logic [1:0] idx;
    logic [7:0] data;
  } item_t;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NCH-1:0]  req_r = '0;
  logic [NCH-1:0]  ack;
  logic [7:0]      data_r [NCH];
  logic [7:0]      data_o;
  logic [1:0]      idx_o;
  logic            valid_o;
  logic            ready = 1'b0;

  item_t           exp_q[$];
  logic [1:0]      grant_log[$];
  int              n_checks = 0;
  int              n_fail   = 0;
  bit              rnd_done = 1'b0;

  always #5 clk = ~clk;

  cdc_2phase_dst_mux #(
    .T          (logic [7:0]),
    .NumChan    (NCH),
    .SyncStages (2)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .async_req_i  (req_r),
    .async_ack_o  (ack),
    .async_data_i (data_r),
    .data_o       (data_o),
    .idx_o        (idx_o),
    .valid_o      (valid_o),
    .ready_i      (ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] log_at(input int k);
    if (k < grant_log.size()) return {6'd0, grant_log[k]};
    return 8'hff;
  endfunction

  // Monitor: every accepted output item must be the oldest outstanding one of its channel.
  initial begin
    int hit;
    forever begin
      @(negedge clk);
      if (rst_n && valid_o && ready) begin
        hit = -1;
        foreach (exp_q[i]) if (hit < 0 && exp_q[i].idx == idx_o) hit = i;
        if (hit < 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: got idx %0d data %0h, expected no item", idx_o, data_o);
        end else begin
          check("sb_data", {24'd0, data_o}, {24'd0, exp_q[hit].data});
          exp_q.delete(hit);
        end
        grant_log.push_back(idx_o);
      end
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    req_r = '0;
    ready = 1'b0;
    for (int c = 0; c < NCH; c++) data_r[c] = 8'h00;
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    grant_log.delete();
  endtask

  task automatic toggle(input int c, input logic [7:0] d);
    item_t it;
    data_r[c] = d;
    req_r[c]  = ~req_r[c];
    it.idx  = 2'(c);
    it.data = d;
    exp_q.push_back(it);
  endtask

  task automatic sender(input int c, input int n, input int maxgap);
    int t;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, maxgap)) @(posedge clk);
      @(posedge clk);
      #1;
      toggle(c, 8'(c * 64 + k));
      t = 0;
      while (ack[c] != req_r[c] && t < 300) begin
        @(posedge clk);
        #1;
        t++;
      end
      if (t >= 300) check("ack_timeout", 32'(ack[c]), 32'(req_r[c]));
    end
  endtask

  task automatic wait_valid(input string name);
    int t = 0;
    while (!valid_o && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) check(name, 32'(valid_o), 32'd1);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) data_r[c] = 8'h00;

    // Reset state
    do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_ack",   32'(ack),     32'd0);
    check("rst_idx",   32'(idx_o),   32'd0);
    check("rst_data",  32'(data_o),  32'd0);

    // Single channel latency: toggle settles before edge k, valid after edge k+2
    do_reset();
    ready = 1'b1;
    toggle(1, 8'hA5);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("lat_early", 32'(valid_o), 32'd0);
    @(negedge clk);
    check("lat_valid", 32'(valid_o), 32'd1);
    check("lat_data",  32'(data_o),  32'hA5);
    check("lat_idx",   32'(idx_o),   32'd1);
    check("lat_ack",   32'(ack),     32'b0010);
    @(negedge clk);
    check("lat_drop",  32'(valid_o), 32'd0);

    // All channels at once: 0,1,2,3 back to back
    do_reset();
    ready = 1'b1;
    for (int c = 0; c < NCH; c++) toggle(c, 8'(8'h10 + c));
    wait_valid("all_timeout");
    for (int i = 0; i < 4; i++) begin
      check("all_burst_valid", 32'(valid_o), 32'd1);
      @(negedge clk);
    end
    check("all_end_valid", 32'(valid_o), 32'd0);
    check("all_ack", 32'(ack), 32'hF);
    for (int i = 0; i < 4; i++) check("all_order", 32'(log_at(i)), 32'(i));

    // Backpressure with channels 1 and 3 pending
    do_reset();
    toggle(1, 8'h31);
    toggle(3, 8'h33);
    wait_valid("bp_timeout");
    for (int i = 0; i < 5; i++) begin
      check("bp_data", 32'(data_o), 32'h31);
      check("bp_idx",  32'(idx_o),  32'd1);
      check("bp_ack",  32'(ack),    32'b0010);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    ready = 1'b1;
    drain("bp_drain");
    check("bp_order0", 32'(log_at(0)), 32'd1);
    check("bp_order1", 32'(log_at(1)), 32'd3);

    // Fairness: channels 0 and 2 re-offer as soon as acked
    do_reset();
    ready = 1'b1;
    fork
      sender(0, 3, 0);
      sender(2, 3, 0);
    join
    drain("fair_drain");
    for (int i = 0; i < 6; i++) check("fair_order", 32'(log_at(i)), (i % 2 == 0) ? 32'd0 : 32'd2);

    // Reset while an item is waiting at the output
    do_reset();
    toggle(3, 8'h77);
    wait_valid("mid_timeout");
    rst_n = 1'b0;
    #1;
    check("mid_valid", 32'(valid_o), 32'd0);
    check("mid_ack",   32'(ack),     32'd0);
    do_reset();
    ready = 1'b1;
    toggle(2, 8'h22);
    toggle(0, 8'h20);
    drain("mid_drain");
    check("mid_first", 32'(log_at(0)), 32'd0);
    check("mid_second", 32'(log_at(1)), 32'd2);

    // Random traffic on all channels with random backpressure
    do_reset();
    rnd_done = 1'b0;
    fork
      begin
        fork
          sender(0, 40, 3);
          sender(1, 40, 3);
          sender(2, 40, 3);
          sender(3, 40, 3);
        join
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(posedge clk);
    #1;
    ready = 1'b1;
    drain("rnd_drain");
    check("rnd_count", 32'(grant_log.size()), 32'd160);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
